posit_decode_pipe: RTL and testbench

//  Parametrised, pipelined posit<N,ES> field decoder; generalises the fixed 32/64-bit posit types to any N/ES.

---
 rtl/posit_decode_pipe.sv | 151 +++++++++++++++
 tb/tb_posit_decode_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_decode_pipe.sv
// rtl/posit_decode_pipe.sv - pipelined posit<N,ES> field decoder (sign, scale, mantissa, zero/NaR)
//
// Two register stages with valid/ready on both sides, full throughput and
// 2-cycle latency. Optional statistics counters are enabled by defining
// the macro POSIT_DECODE_STATS_EN.
//
// Ports:
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      input posit valid
//   in_ready   out  1      decoder can accept in_data this cycle
//   in_data    in   N      raw posit bits
//   out_valid  out  1      decoded result valid
//   out_ready  in   1      downstream accepts result
//   out_sign   out  1      sign bit
//   out_scale  out  SW     signed scale = k*2^ES + e
//   out_mant   out  FW+1   1.f, hidden bit at MSB, fraction left-aligned
//   out_zero   out  1      input was all zeros
//   out_nar    out  1      input was NaR
//   stats_clr  in   1      (POSIT_DECODE_STATS_EN) clear both counters
//   stat_zero  out  32     (POSIT_DECODE_STATS_EN) zero results delivered
//   stat_nar   out  32     (POSIT_DECODE_STATS_EN) NaR results delivered
module posit_decode_pipe #(
  parameter  int N  = 32,
  parameter  int ES = 2,
  localparam int SW = $clog2(N) + ES + 1,
  localparam int FW = N - ES - 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [SW-1:0] out_scale,
  output logic [FW:0]   out_mant,
  output logic          out_zero,
`ifdef POSIT_DECODE_STATS_EN
  output logic          out_nar,
  input  logic          stats_clr,
  output logic [31:0]   stat_zero,
  output logic [31:0]   stat_nar
`else
  output logic          out_nar
`endif
);

  localparam int BW = N - 1;  // body width (posit without sign bit)

  logic          s1_valid;
  logic          s1_sign;
  logic          s1_zero;
  logic          s1_nar;
  logic [BW-1:0] s1_body;

  logic          s2_adv;

  // Output stage frees up when empty or draining; stage 1 frees up when
  // empty or when it can move into stage 2.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Stage 2 combinational decode of the two's-complemented body.
  logic          first;
  logic          stop;
  logic [SW-1:0] run;
  logic [SW-1:0] k;
  logic [N-4:0]  rem;
  logic [SW-1:0] e_ext;
  logic [SW-1:0] scale_c;

  always_comb begin
    first = s1_body[BW-1];
    run   = '0;
    stop  = 1'b0;
    for (int i = BW - 1; i >= 0; i--) begin
      if (!stop) begin
        if (s1_body[i] == first) run = run + 1'b1;
        else                     stop = 1'b1;
      end
    end
    k = first ? (run - 1'b1) : (-run);
    // Bits after regime and terminator. The top two body bits always belong
    // to the regime/terminator, so start from bit N-4 and shift by run-1;
    // a run reaching the LSB shifts everything out, so e and fraction read 0.
    rem     = s1_body[N-4:0] << (run - 1'b1);
    scale_c = (k << ES) | e_ext;
  end

  if (ES > 0) begin : g_exp
    assign e_ext = SW'(rem[N-4 -: ES]);
  end else begin : g_noexp
    assign e_ext = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_nar    <= 1'b0;
      s1_body   <= '0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_scale <= '0;
      out_mant  <= '0;
      out_zero  <= 1'b0;
      out_nar   <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_sign <= s1_sign;
          out_zero <= s1_zero;
          out_nar  <= s1_nar;
          if (s1_zero || s1_nar) begin
            out_scale <= '0;
            out_mant  <= '0;
          end else begin
            out_scale <= scale_c;
            out_mant  <= {1'b1, rem[FW-1:0]};
          end
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= in_data[N-1];
          s1_zero <= (in_data == '0);
          s1_nar  <= in_data[N-1] && (in_data[N-2:0] == '0);
          s1_body <= in_data[N-1] ? (-in_data[N-2:0]) : in_data[N-2:0];
        end
      end
    end
  end

`ifdef POSIT_DECODE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      stat_zero <= '0;
      stat_nar  <= '0;
    end else if (out_valid && out_ready) begin
      if (out_zero) stat_zero <= stat_zero + 32'd1;
      if (out_nar)  stat_nar  <= stat_nar + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb/tb_posit_decode_pipe.sv - scoreboard testbench for posit_decode_pipe (N=32, ES=2)
module tb_posit_decode_pipe;
  localparam int N  = 32;
  localparam int ES = 2;
  localparam int SW = 8;
  localparam int FW = 27;

  typedef struct packed {
    logic          sign;
    logic [SW-1:0] scale;
    logic [FW:0]   mant;
    logic          zero;
    logic          nar;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sign;
  logic [SW-1:0] out_scale;
  logic [FW:0]   out_mant;
  logic          out_zero;
  logic          out_nar;
`ifdef POSIT_DECODE_STATS_EN
  logic          stats_clr = 1'b0;
  logic [31:0]   stat_zero;
  logic [31:0]   stat_nar;
`endif

  always #5 clk = ~clk;

  posit_decode_pipe #(.N(N), .ES(ES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_scale(out_scale), .out_mant(out_mant),
    .out_zero(out_zero),
`ifdef POSIT_DECODE_STATS_EN
    .out_nar(out_nar), .stats_clr(stats_clr),
    .stat_zero(stat_zero), .stat_nar(stat_nar)
`else
    .out_nar(out_nar)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   mon_en = 1'b1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic exp_t mk(input logic s, input logic [SW-1:0] sc, input logic [FW:0] m,
                              input logic z, input logic n);
    exp_t e;
    e.sign = s; e.scale = sc; e.mant = m; e.zero = z; e.nar = n;
    return e;
  endfunction

  // Monitor: pops and compares on each output handshake, and checks that a
  // stalled output holds its value until it is taken.
  exp_t cur, prev, want;
  bit   prev_stall = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        prev_stall = 1'b0;
      end else if (out_valid) begin
        cur = mk(out_sign, out_scale, out_mant, out_zero, out_nar);
        if (prev_stall) check("stall_hold", 64'(cur), 64'(prev));
        if (out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 64'(cur), 64'h0);
          end else begin
            want = sb.pop_front();
            check("result", 64'(cur), 64'(want));
          end
        end
        prev_stall = !out_ready;
        prev = cur;
      end else begin
        if (prev_stall) check("valid_dropped_in_stall", 64'(out_valid), 64'h1);
        prev_stall = 1'b0;
      end
    end
  end

  // Present one posit and hold it until accepted; push expectation on accept.
  task automatic send(input logic [N-1:0] d, input exp_t e, input bit push);
    bit acc;
    int cnt;
    in_valid = 1'b1;
    in_data  = d;
    cnt = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      if (acc && push) sb.push_back(e);
      @(posedge clk);
      #1;
      cnt++;
    end while (!acc && cnt < 200);
    if (!acc) check("send_timeout", 64'(acc), 64'h1);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain();
    int cnt = 0;
    while (sb.size() != 0 && cnt < 500) begin
      @(posedge clk);
      cnt++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'h0);
  endtask

  localparam logic [FW:0] ONE = 28'h8000000;

  logic [N-1:0] sv [8];
  exp_t         se [8];

  initial begin
    sv[0] = 32'h40000000; se[0] = mk(1'b0, 8'd0,   ONE,          1'b0, 1'b0);
    sv[1] = 32'h48000000; se[1] = mk(1'b0, 8'd1,   ONE,          1'b0, 1'b0);
    sv[2] = 32'h50000000; se[2] = mk(1'b0, 8'd2,   ONE,          1'b0, 1'b0);
    sv[3] = 32'h44000000; se[3] = mk(1'b0, 8'd0,   28'hC000000,  1'b0, 1'b0);
    sv[4] = 32'h20000000; se[4] = mk(1'b0, 8'hFC,  ONE,          1'b0, 1'b0);
    sv[5] = 32'h60000000; se[5] = mk(1'b0, 8'd4,   ONE,          1'b0, 1'b0);
    sv[6] = 32'hB8000000; se[6] = mk(1'b1, 8'd1,   ONE,          1'b0, 1'b0);
    sv[7] = 32'h7FFFFFFF; se[7] = mk(1'b0, 8'd120, ONE,          1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'h0);
    check("reset_in_ready",  64'(in_ready),  64'h1);
    check("reset_out_data",  64'(mk(out_sign, out_scale, out_mant, out_zero, out_nar)), 64'h0);
    @(posedge clk);
    #1;

    // Latency: result appears exactly two cycles after acceptance.
    send(32'h40000000, mk(1'b0, 8'd0, ONE, 1'b0, 1'b0), 1'b1);
    @(negedge clk);
    check("latency_cycle1", 64'(out_valid), 64'h0);
    @(negedge clk);
    check("latency_cycle2", 64'(out_valid), 64'h1);
    drain();

    // Directed vectors, back to back.
    send(32'h48000000, mk(1'b0, 8'd0 + 8'd1, ONE, 1'b0, 1'b0), 1'b1);
    send(32'hC0000000, mk(1'b1, 8'd0,   ONE,  1'b0, 1'b0), 1'b1);
    send(32'h00000000, mk(1'b0, 8'd0,   28'h0, 1'b1, 1'b0), 1'b1);
    send(32'h80000000, mk(1'b1, 8'd0,   28'h0, 1'b0, 1'b1), 1'b1);
    send(32'h7FFFFFFF, mk(1'b0, 8'd120, ONE,  1'b0, 1'b0), 1'b1);
    send(32'h00000001, mk(1'b0, 8'h88,  ONE,  1'b0, 1'b0), 1'b1);
    send(32'h80000001, mk(1'b1, 8'd120, ONE,  1'b0, 1'b0), 1'b1);
    drain();

    // Stream of 8 with out_ready toggling.
    fork
      begin
        for (int i = 0; i < 8; i++) send(sv[i], se[i], 1'b1);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Fill both stages, then flush with reset.
    out_ready = 1'b0;
    send(32'h48000000, se[1], 1'b0);
    send(32'h50000000, se[2], 1'b0);
    @(negedge clk);
    check("flush_full_valid", 64'(out_valid), 64'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'h0);
    check("flush_in_ready",  64'(in_ready),  64'h1);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("flush_no_stale", 64'(out_valid), 64'h0);
    @(posedge clk);
    #1;
    send(32'h60000000, se[5], 1'b1);
    send(32'hB8000000, se[6], 1'b1);
    drain();

`ifdef POSIT_DECODE_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h00000000, mk(1'b0, 8'd0, 28'h0, 1'b1, 1'b0), 1'b1);
    for (int i = 0; i < 2; i++) send(32'h80000000, mk(1'b1, 8'd0, 28'h0, 1'b0, 1'b1), 1'b1);
    send(32'h40000000, se[0], 1'b1);
    drain();
    check("stat_zero", 64'(stat_zero), 64'd3);
    check("stat_nar",  64'(stat_nar),  64'd2);
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    check("stat_zero_clr", 64'(stat_zero), 64'd0);
    check("stat_nar_clr",  64'(stat_nar),  64'd0);
`endif

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
